// File: rtl/rng_gen_2.sv
// TRNG conditioner/packer: synchronise and XOR oscillators, run a repetition-count health test, pack words.
// Define RNG_VN_DEBIAS_EN to enable von Neumann debiasing of the raw bit stream.
module rng_gen_2 #(
  parameter int unsigned NUM_OSC     = 4,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WARMUP_CYC  = 64,
  parameter int unsigned REP_LIMIT   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_OSC-1:0] osc_in,
  output logic               osc_en,
  output logic [WORD_W-1:0]  rnd_data,
  output logic               rnd_valid,
  input  logic               rnd_ready,
  output logic               health_fail
);

  localparam int unsigned BC_W = $clog2(WORD_W + 1);
  localparam int unsigned RC_W = $clog2(REP_LIMIT + 1);
  localparam int unsigned WC_W = $clog2(WARMUP_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_COLLECT, S_HOLD, S_FAIL} state_t;

  logic [NUM_OSC-1:0] sync_q [SYNC_STAGES];
  logic               raw_q;

  state_t            state, state_nxt;
  logic [WC_W-1:0]   warm_cnt, warm_nxt;
  logic [BC_W-1:0]   bit_cnt, bit_nxt;
  logic [RC_W-1:0]   rep_cnt, rep_nxt, rep_run;
  logic              last_bit, last_nxt;
  logic [WORD_W-1:0] word, word_nxt, data_nxt;
  logic              valid_nxt, health_nxt, osc_en_nxt;
  logic              shift_en, shift_bit;
`ifdef RNG_VN_DEBIAS_EN
  logic              vn_phase, vn_phase_nxt;
  logic              vn_first, vn_first_nxt;
`endif

  // Metastability synchroniser followed by the XOR combiner flop
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      raw_q <= 1'b0;
    end else begin
      sync_q[0] <= osc_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      raw_q <= ^sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      warm_cnt    <= '0;
      bit_cnt     <= '0;
      rep_cnt     <= '0;
      last_bit    <= 1'b0;
      word        <= '0;
      rnd_data    <= '0;
      rnd_valid   <= 1'b0;
      health_fail <= 1'b0;
      osc_en      <= 1'b0;
`ifdef RNG_VN_DEBIAS_EN
      vn_phase    <= 1'b0;
      vn_first    <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      warm_cnt    <= warm_nxt;
      bit_cnt     <= bit_nxt;
      rep_cnt     <= rep_nxt;
      last_bit    <= last_nxt;
      word        <= word_nxt;
      rnd_data    <= data_nxt;
      rnd_valid   <= valid_nxt;
      health_fail <= health_nxt;
      osc_en      <= osc_en_nxt;
`ifdef RNG_VN_DEBIAS_EN
      vn_phase    <= vn_phase_nxt;
      vn_first    <= vn_first_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    warm_nxt   = warm_cnt;
    bit_nxt    = bit_cnt;
    rep_nxt    = rep_cnt;
    rep_run    = rep_cnt;
    last_nxt   = last_bit;
    word_nxt   = word;
    data_nxt   = rnd_data;
    health_nxt = health_fail;
    shift_en   = 1'b0;
    shift_bit  = 1'b0;
    // Oscillator enable lags the state by one edge
    osc_en_nxt = (state == S_WARMUP) || (state == S_COLLECT) || (state == S_HOLD);
`ifdef RNG_VN_DEBIAS_EN
    vn_phase_nxt = vn_phase;
    vn_first_nxt = vn_first;
`endif

    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nxt = S_WARMUP;
          warm_nxt  = '0;
        end
      end
      S_WARMUP: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (warm_cnt == WC_W'(WARMUP_CYC - 1)) begin
          state_nxt = S_COLLECT;
        end else begin
          warm_nxt = warm_cnt + WC_W'(1);
        end
      end
      S_COLLECT: begin
        rep_run  = ((rep_cnt == '0) || (raw_q != last_bit)) ? RC_W'(1) : rep_cnt + RC_W'(1);
        rep_nxt  = rep_run;
        last_nxt = raw_q;
`ifdef RNG_VN_DEBIAS_EN
        if (!vn_phase) begin
          vn_phase_nxt = 1'b1;
          vn_first_nxt = raw_q;
        end else begin
          vn_phase_nxt = 1'b0;
          shift_en     = (vn_first != raw_q);
          shift_bit    = vn_first;
        end
`else
        shift_en  = 1'b1;
        shift_bit = raw_q;
`endif
        if (shift_en) begin
          word_nxt = {word[WORD_W-2:0], shift_bit};
          bit_nxt  = bit_cnt + BC_W'(1);
        end
        // Health failure outranks word completion on the same edge
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (rep_run == RC_W'(REP_LIMIT)) begin
          state_nxt  = S_FAIL;
          health_nxt = 1'b1;
        end else if (shift_en && (bit_cnt == BC_W'(WORD_W - 1))) begin
          state_nxt = S_HOLD;
          data_nxt  = word_nxt;
        end
      end
      S_HOLD: begin
        if (rnd_valid && rnd_ready) begin
          state_nxt = enable ? S_COLLECT : S_IDLE;
          bit_nxt   = '0;
        end else if (!enable) begin
          state_nxt = S_IDLE;
        end
      end
      S_FAIL: state_nxt = S_FAIL;
      default: state_nxt = S_IDLE;
    endcase

    // Run-length and pairing restart whenever collection is not continuing
    if (state_nxt != S_COLLECT) begin
      rep_nxt = '0;
`ifdef RNG_VN_DEBIAS_EN
      vn_phase_nxt = 1'b0;
`endif
    end
    if ((state_nxt != S_COLLECT) && (state_nxt != S_HOLD)) begin
      bit_nxt  = '0;
      word_nxt = '0;
    end
    valid_nxt = (state_nxt == S_HOLD);
  end

endmodule
